// File: rtl/bandai2003_pkg.sv
// Constants and state encoding shared between the Bandai 2003 mapper and the console-side authenticator.
package bandai2003_pkg;

    localparam logic [7:0]  ADDR_ACK         = 8'h5A;
    localparam logic [7:0]  ADDR_NAK         = 8'hA5;
    localparam logic [15:0] AUTH_MAGIC       = 16'h28A0;
    localparam int          AUTH_FRAME_LEN   = 18;
    localparam int          AUTH_PAYLOAD_LEN = AUTH_FRAME_LEN - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_NAK,
        ST_HUNT,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } auth_state_t;

endpackage

// File: rtl/bandai_auth_rx_if.sv
// Request, cartridge serial line, unlock address drive and result signals of the authenticator.
interface bandai_auth_rx_if;
    logic        start;
    logic        si;
    logic [7:0]  addr_out;
    logic        addr_oe;
    logic        busy;
    logic        done;
    logic        pass;
    logic        auth;
    logic [15:0] word;

    modport master (
        output start, si,
        input  addr_out, addr_oe, busy, done, pass, auth, word
    );

    modport slave (
        input  start, si,
        output addr_out, addr_oe, busy, done, pass, auth, word
    );
endinterface

// File: rtl/bandai_auth_deser.sv
// LSB-first payload capture: each enabled edge writes the serial bit at the current counter position.
module bandai_auth_deser (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_shift_en,
    input  logic        i_bit,
    output logic [15:0] o_word,
    output logic        o_last
);
    logic [15:0] r_word;
    logic [3:0]  r_cnt;

    // The word is deliberately not cleared with the counter so an aborted attempt keeps the old payload.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= 16'h0000;
            r_cnt  <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_shift_en) begin
            r_word[r_cnt] <= i_bit;
            r_cnt         <= r_cnt + 4'd1;
        end
    end

    assign o_word = r_word;
    assign o_last = (r_cnt == 4'd15);
endmodule

// File: rtl/bandai_auth_rx.sv
// Drives the 5A/A5 unlock, receives the 18-bit cartridge frame and latches sticky AUTH on a magic match.
// Define AUTH_TIMEOUT_EN to abort HUNT after TIMEOUT edges without a start bit.
module bandai_auth_rx
    import bandai2003_pkg::*;
#(
    parameter logic [15:0] MAGIC   = AUTH_MAGIC,
    parameter int          TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    bandai_auth_rx_if.slave  bus
);
    auth_state_t r_state;
    auth_state_t w_state_nxt;
    logic        r_pass;
    logic        r_auth;
    logic [7:0]  w_addr_out;
    logic        w_addr_oe;
    logic [15:0] w_word;
    logic        w_last;
    logic        w_timeout;
    logic        w_frame_ok;

    bandai_auth_deser u_deser (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (r_state == ST_HUNT),
        .i_shift_en (r_state == ST_DATA),
        .i_bit      (bus.si),
        .o_word     (w_word),
        .o_last     (w_last)
    );

`ifdef AUTH_TIMEOUT_EN
    logic [7:0] r_hunt_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hunt_cnt <= 8'd0;
        end else if (r_state == ST_NAK) begin
            r_hunt_cnt <= 8'd0;
        end else if (r_state == ST_HUNT) begin
            r_hunt_cnt <= r_hunt_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ST_HUNT) && (r_hunt_cnt == 8'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Stop bit must be zero as well; a correct payload with the line still high is a failed frame.
    assign w_frame_ok = (r_state == ST_STOP) && !bus.si && (w_word == MAGIC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_pass  <= 1'b0;
            r_auth  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && bus.start) begin
                r_pass <= 1'b0;
            end else if (r_state == ST_STOP) begin
                r_pass <= w_frame_ok;
            end
            r_auth <= r_auth | w_frame_ok;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_out  = 8'h00;
        w_addr_oe   = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_ACK;
            ST_ACK: begin
                w_addr_out  = ADDR_ACK;
                w_addr_oe   = 1'b1;
                w_state_nxt = ST_NAK;
            end
            ST_NAK: begin
                w_addr_out  = ADDR_NAK;
                w_addr_oe   = 1'b1;
                w_state_nxt = ST_HUNT;
            end
            ST_HUNT: begin
                if (!bus.si) begin
                    w_state_nxt = ST_DATA;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DATA: if (w_last) w_state_nxt = ST_STOP;
            ST_STOP: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.addr_out = w_addr_out;
    assign bus.addr_oe  = w_addr_oe;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.pass     = r_pass;
    assign bus.auth     = r_auth;
    assign bus.word     = w_word;
endmodule

// File: tb/tb_bandai_auth_rx.sv
// Scoreboarded bench: a mapper model answers the unlock, expected results queue per attempt, a monitor checks each DONE.
module tb_bandai_auth_rx;
    import bandai2003_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bandai_auth_rx_if bus();

`ifdef AUTH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    bandai_auth_rx #(.MAGIC(16'h28A0), .TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int          cyc;
        logic        pass;
        logic        auth;
        logic [15:0] word;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          cyc      = 0;
    logic        exp_auth = 1'b0;
    logic        m_en     = 1'b0;
    logic [15:0] m_payload = 16'h0000;
    logic        m_stop   = 1'b0;
    int          m_delay  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse consumes one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cyc %0d, required no pending attempt", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("pass", {31'd0, bus.pass}, {31'd0, e.pass});
                chk("auth", {31'd0, bus.auth}, {31'd0, e.auth});
                chk("word", {16'd0, bus.word}, {16'd0, e.word});
            end
        end
    end

    // Mapper model: after seeing A5 it sends start bit, payload LSB first, stop bit, then idles high.
    initial begin
        bus.si = 1'b1;
        forever begin
            @(negedge clk);
            if (m_en && rst_n && bus.addr_out == 8'hA5) begin
                @(posedge clk);
                repeat (m_delay) @(posedge clk);
                #1 bus.si = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk);
                    #1 bus.si = m_payload[i];
                end
                @(posedge clk);
                #1 bus.si = m_stop;
                @(posedge clk);
                #1 bus.si = 1'b1;
            end
        end
    end

    task automatic issue_start(output int edge0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        edge0     = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && n_done < target; i++) begin
            @(negedge clk);
            #2;
        end
        chk("done_seen", {31'd0, (n_done >= target)}, 32'd1);
    endtask

    task automatic attempt(input logic [15:0] payload, input logic stop, input int delay, input logic exp_pass);
        int e0;
        int target;
        m_payload = payload;
        m_stop    = stop;
        m_delay   = delay;
        m_en      = 1'b1;
        target    = n_done + 1;
        issue_start(e0);
        chk("busy_c1", {31'd0, bus.busy}, 32'd1);
        chk("addr_c1", {24'd0, bus.addr_out}, 32'h5A);
        exp_auth = exp_auth | exp_pass;
        sb.push_back('{e0 + 20 + delay, exp_pass, exp_auth, payload});
        wait_done(target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr_out"}, {24'd0, bus.addr_out}, 32'd0);
        chk({tag, "_addr_oe"},  {31'd0, bus.addr_oe},  32'd0);
        chk({tag, "_busy"},     {31'd0, bus.busy},     32'd0);
        chk({tag, "_done"},     {31'd0, bus.done},     32'd0);
        chk({tag, "_pass"},     {31'd0, bus.pass},     32'd0);
        chk({tag, "_auth"},     {31'd0, bus.auth},     32'd0);
        chk({tag, "_word"},     {16'd0, bus.word},     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int d0;
        int target;
        logic [31:0] oe_mask;
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        attempt(16'h28A1, 1'b0, 0, 1'b0);   // wrong payload
        attempt(16'h28A0, 1'b1, 0, 1'b0);   // missing stop bit
        attempt(16'h28A0, 1'b0, 0, 1'b1);   // nominal
        attempt(16'h28A1, 1'b0, 0, 1'b0);   // bad attempt keeps AUTH
        attempt(16'h28A0, 1'b0, 10, 1'b1);  // late start bit

`ifdef AUTH_TIMEOUT_EN
        m_en   = 1'b0;
        target = n_done + 1;
        issue_start(e0);
        sb.push_back('{e0 + 10, 1'b0, exp_auth, 16'h28A0});
        wait_done(target);
`endif

        // Reset in the middle of the payload.
        m_payload = 16'h28A0;
        m_stop    = 1'b0;
        m_delay   = 0;
        m_en      = 1'b1;
        issue_start(e0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_auth = 1'b0;
        #20 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        attempt(16'h28A0, 1'b0, 0, 1'b1);

        // START pulses while busy must be ignored.
        m_payload = 16'h1234;
        m_stop    = 1'b0;
        m_delay   = 0;
        d0        = n_done;
        oe_mask   = 32'd0;
        issue_start(e0);
        sb.push_back('{e0 + 20, 1'b0, exp_auth, 16'h1234});
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.addr_oe) oe_mask[c] = 1'b1;
            bus.start = (c == 5 || c == 15);
        end
        bus.start = 1'b0;
        #2;
        chk("oe_mask", oe_mask, 32'h0000_0006);
        chk("one_done", n_done - d0, 32'd1);

        // START held through DONE restarts after a single IDLE cycle.
        m_payload = 16'h28A0;
        target    = n_done + 2;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        sb.push_back('{e0 + 20, 1'b1, 1'b1, 16'h28A0});
        sb.push_back('{e0 + 42, 1'b1, 1'b1, 16'h28A0});
        repeat (21) @(posedge clk);
        #1 chk("idle_gap_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("restart_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(target);

        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
